grp_scan_arb: RTL and testbench

GRP_SCAN_ARB -- requirements
Module: grp_scan_arb

---
 rtl/grp_scan_arb.sv | 135 +++++++++++++
 tb/tb_grp_scan_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grp_scan_arb.sv
// Round-robin scan arbiter over NGRP request groups: snapshots the active groups, grants them in turn.
// Optional GRP_SCAN_RESNAP_EN: requests that become active mid-pass are folded in on every accepted grant.
module grp_scan_arb #(
   parameter int unsigned NGRP = 8,
   parameter int unsigned GW   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NGRP*GW-1:0]        req_vec,
   input  logic [NGRP-1:0]           grp_en,
   input  logic                      start,
   input  logic                      gnt_ready,
   output logic                      busy,
   output logic                      gnt_valid,
   output logic [$clog2(NGRP)-1:0]   gnt_id,
   output logic                      done,
   output logic [$clog2(NGRP):0]     gnt_count
);

   localparam int unsigned IW = $clog2(NGRP);
   localparam int unsigned CW = IW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SNAP  = 3'd1;
   localparam logic [2:0] S_ARB   = 3'd2;
   localparam logic [2:0] S_GRANT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state, state_n;
   logic [NGRP-1:0] pending, pending_n;
   logic [NGRP-1:0] active;
   logic [NGRP-1:0] gbit;
   logic [IW-1:0]   rr_ptr, rr_n;
   logic [IW-1:0]   id_n;
   logic [IW-1:0]   sel_id;
   logic [CW-1:0]   cnt_n;

   // A group is active when enabled and any of its request bits is set
   always_comb begin
      active = '0;
      for (int unsigned g = 0; g < NGRP; g++) begin
         active[g] = grp_en[g] & (|req_vec[g*GW +: GW]);
      end
   end

   // First pending group at or after rr_ptr, wrapping
   always_comb begin
      logic        found;
      int unsigned idx;
      found  = 1'b0;
      idx    = 0;
      sel_id = '0;
      for (int unsigned i = 0; i < NGRP; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= NGRP) idx = idx - NGRP;
         if (!found && pending[IW'(idx)]) begin
            found  = 1'b1;
            sel_id = IW'(idx);
         end
      end
   end

   always_comb begin
      gbit         = '0;
      gbit[gnt_id] = 1'b1;
   end

   // Next-state and datapath updates
   always_comb begin
      state_n   = state;
      pending_n = pending;
      rr_n      = rr_ptr;
      cnt_n     = gnt_count;
      id_n      = gnt_id;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_SNAP;
         end
         S_SNAP: begin
            pending_n = active;
            cnt_n     = '0;
            state_n   = S_ARB;
         end
         S_ARB: begin
            if (pending == '0) begin
               state_n = S_DONE;
            end else begin
               id_n    = sel_id;
               state_n = S_GRANT;
            end
         end
         S_GRANT: begin
            if (gnt_ready) begin
`ifdef GRP_SCAN_RESNAP_EN
               pending_n = (pending | active) & ~gbit;
`else
               pending_n = pending & ~gbit;
`endif
               rr_n    = (gnt_id == IW'(NGRP - 1)) ? '0 : gnt_id + IW'(1);
               cnt_n   = gnt_count + CW'(1);
               state_n = S_ARB;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pending   <= '0;
         rr_ptr    <= '0;
         gnt_count <= '0;
         gnt_id    <= '0;
         busy      <= 1'b0;
         gnt_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         rr_ptr    <= rr_n;
         gnt_count <= cnt_n;
         gnt_id    <= id_n;
         busy      <= (state_n != S_IDLE);
         gnt_valid <= (state_n == S_GRANT);
         done      <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_grp_scan_arb.sv
// Self-checking bench for grp_scan_arb: directed table, hold/reset/late-request sequences, random passes
// checked against a transaction-level round-robin model. Honours GRP_SCAN_RESNAP_EN.
module tb_grp_scan_arb;

   localparam int NG = 8;
   localparam int GW = 32;
   localparam int NR = NG * GW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NR-1:0] req_vec = '0;
   logic [NG-1:0] grp_en = '0;
   logic          start = 1'b0;
   logic          gnt_ready = 1'b0;
   logic          busy, gnt_valid, done;
   logic [2:0]    gnt_id;
   logic [3:0]    gnt_count;

   int checks = 0;
   int errors = 0;
   int m_rr = 0;
   int got_q[$];
   int exp_q[$];

   grp_scan_arb #(.NGRP(NG), .GW(GW)) dut (
      .clk(clk), .rst(rst), .req_vec(req_vec), .grp_en(grp_en), .start(start),
      .gnt_ready(gnt_ready), .busy(busy), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
      .done(done), .gnt_count(gnt_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NR-1:0]     req;
      logic [NG-1:0]     en;
      logic [3:0]        n;
      logic [7:0][2:0]   ids;
   } vec_t;

   vec_t tv[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [NR-1:0] mk_req(input logic [NG-1:0] m, input logic [GW-1:0] pat);
      logic [NR-1:0] r;
      r = '0;
      for (int g = 0; g < NG; g++) if (m[g]) r[g*GW +: GW] = pat;
      return r;
   endfunction

   function automatic logic [NR-1:0] rand_req();
      logic [NR-1:0] r;
      r = '0;
      for (int g = 0; g < NG; g++) begin
         case ($urandom_range(0, 3))
            0, 1:    r[g*GW +: GW] = '0;
            2:       r[g*GW + $urandom_range(0, GW-1)] = 1'b1;
            default: r[g*GW +: GW] = $urandom;
         endcase
      end
      return r;
   endfunction

   function automatic logic [NG-1:0] act_of(input logic [NR-1:0] r, input logic [NG-1:0] e);
      logic [NG-1:0] a;
      for (int g = 0; g < NG; g++) a[g] = e[g] && (r[g*GW +: GW] != '0);
      return a;
   endfunction

   // Reference: active ids >= pointer in ascending order, then the ones below it
   task automatic model(input logic [NG-1:0] act);
      exp_q.delete();
      for (int g = m_rr; g < NG; g++) if (act[g]) exp_q.push_back(g);
      for (int g = 0; g < m_rr; g++) if (act[g]) exp_q.push_back(g);
      if (exp_q.size() > 0) m_rr = (exp_q[$] + 1) % NG;
   endtask

   task automatic cmp_order(input string nm);
      chk({nm, "_ngrants"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk({nm, "_id"}, 32'(got_q[k]), 32'(exp_q[k]));
   endtask

   // Runs one pass; hold>0 withholds gnt_ready on the first grant and pulses start meanwhile
   task automatic run_pass(input logic [NR-1:0] r, input logic [NG-1:0] e, input int pct,
                           input bit scr, input int hold);
      int cyc, first_v, hold_cnt;
      bit pend_unacc, fin;
      logic [2:0] last_id;
      got_q.delete();
      req_vec = r; grp_en = e; gnt_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk("snap_busy", 32'(busy), 1);
      tick();
      chk("arb_cnt_clr", 32'(gnt_count), 0);
      chk("arb_valid", 32'(gnt_valid), 0);
`ifdef GRP_SCAN_RESNAP_EN
      req_vec = '0;
`else
      if (scr) req_vec = rand_req();
`endif
      cyc = 2; first_v = 0; pend_unacc = 0; hold_cnt = hold; fin = 0; last_id = '0;
      while (!fin && cyc < 300) begin
         tick(); cyc++;
         start = 1'b0;
         if (done) begin
            fin = 1;
            chk("done_valid", 32'(gnt_valid), 0);
            chk("done_cnt", 32'(gnt_count), 32'(got_q.size()));
            if (first_v == 0) chk("empty_lat", 32'(cyc), 3);
         end else if (gnt_valid) begin
            if (first_v == 0) begin
               first_v = cyc;
               chk("first_lat", 32'(cyc), 3);
            end
            if (pend_unacc) chk("id_stable", 32'(gnt_id), 32'(last_id));
            last_id = gnt_id;
            if (hold_cnt > 0) begin
               gnt_ready = 1'b0;
               start = (hold_cnt == hold - 1);
               hold_cnt--;
               pend_unacc = 1;
            end else begin
               gnt_ready = ($urandom_range(0, 99) < pct);
               pend_unacc = !gnt_ready;
               if (gnt_ready) got_q.push_back(int'(gnt_id));
            end
         end else begin
            if (pend_unacc) chk("valid_held", 32'(gnt_valid), 1);
            pend_unacc = 0;
            gnt_ready = 1'($urandom_range(0, 1));
         end
      end
      if (!fin) chk("pass_timeout", 0, 1);
      gnt_ready = 1'b0;
      tick();
      chk("post_done", 32'(done), 0);
      chk("post_busy", 32'(busy), 0);
      chk("cnt_hold", 32'(gnt_count), 32'(got_q.size()));
   endtask

   initial begin
      int cyc;
      bit fin;
      logic [NR-1:0] r;
      logic [NG-1:0] e;

      tv[0].req = mk_req(8'b0101_0010, 32'h0000_0100); tv[0].en = 8'hFF; tv[0].n = 4'd3;
      tv[0].ids = '0; tv[0].ids[0] = 3'd1; tv[0].ids[1] = 3'd4; tv[0].ids[2] = 3'd6;
      tv[1].req = mk_req(8'b0010_0100, 32'h8000_0000); tv[1].en = 8'hDF; tv[1].n = 4'd1;
      tv[1].ids = '0; tv[1].ids[0] = 3'd2;
      tv[2].req = '0; tv[2].en = 8'hFF; tv[2].n = 4'd0; tv[2].ids = '0;
      tv[3].req = mk_req(8'b0001_0000, 32'h0001_0000); tv[3].en = 8'hFF; tv[3].n = 4'd1;
      tv[3].ids = '0; tv[3].ids[0] = 3'd4;
      tv[4].req = mk_req(8'b1000_1001, 32'h0000_0001); tv[4].en = 8'hFF; tv[4].n = 4'd3;
      tv[4].ids = '0; tv[4].ids[0] = 3'd7; tv[4].ids[1] = 3'd0; tv[4].ids[2] = 3'd3;
      tv[5].req = mk_req(8'hFF, 32'hFFFF_FFFF); tv[5].en = 8'h0F; tv[5].n = 4'd4;
      tv[5].ids = '0; tv[5].ids[0] = 3'd0; tv[5].ids[1] = 3'd1; tv[5].ids[2] = 3'd2; tv[5].ids[3] = 3'd3;

      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(gnt_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_id", 32'(gnt_id), 0);
      chk("rst_cnt", 32'(gnt_count), 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Directed table, gnt_ready always accepted
      for (int i = 0; i < 6; i++) begin
         run_pass(tv[i].req, tv[i].en, 100, 1'b0, 0);
         exp_q.delete();
         for (int k = 0; k < int'(tv[i].n); k++) exp_q.push_back(int'(tv[i].ids[k]));
         cmp_order("tbl");
         model(act_of(tv[i].req, tv[i].en));
      end

      // Withheld gnt_ready for 4 cycles with a stray start in the middle
      r = mk_req(8'b0100_0100, 32'h0000_0010);
      model(act_of(r, 8'hFF));
      run_pass(r, 8'hFF, 100, 1'b0, 4);
      cmp_order("hold");
      tick();
      chk("stray_start_busy", 32'(busy), 0);

      // Random passes
      for (int p = 0; p < 40; p++) begin
         r = rand_req();
         e = NG'($urandom);
         model(act_of(r, e));
         run_pass(r, e, int'($urandom_range(30, 100)), 1'b1, 0);
         cmp_order("rand");
      end

      // Reset during GRANT: outputs clear without waiting for a clock, no done follows
      req_vec = mk_req(8'b0000_0110, 32'h0000_0002); grp_en = 8'hFF; start = 1'b1;
      tick(); start = 1'b0; tick(); tick();
      chk("pre_rst_valid", 32'(gnt_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_valid", 32'(gnt_valid), 0);
      chk("arst_id", 32'(gnt_id), 0);
      chk("arst_cnt", 32'(gnt_count), 0);
      chk("arst_done", 32'(done), 0);
      @(posedge clk); #1 rst = 1'b0;
      m_rr = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("after_rst_done", 32'(done), 0);
         chk("after_rst_busy", 32'(busy), 0);
      end

      // Group 3 turns active as group 1 is granted
      req_vec = mk_req(8'b0000_0010, 32'h0000_4000); grp_en = 8'hFF; start = 1'b1;
      tick(); start = 1'b0; tick(); tick();
      chk("late_first_valid", 32'(gnt_valid), 1);
      chk("late_first_id", 32'(gnt_id), 1);
      got_q.delete();
      got_q.push_back(int'(gnt_id));
      gnt_ready = 1'b1;
      req_vec = mk_req(8'b0000_1000, 32'h0000_4000);
      tick();
      gnt_ready = 1'b0;
      cyc = 0; fin = 0;
      while (!fin && cyc < 20) begin
         cyc++;
         if (done) begin
            fin = 1;
            chk("late_cnt", 32'(gnt_count), 32'(got_q.size()));
         end else if (gnt_valid) begin
            gnt_ready = 1'b1;
            got_q.push_back(int'(gnt_id));
            req_vec = '0;
         end else begin
            gnt_ready = 1'b0;
         end
         if (!fin) tick();
      end
      if (!fin) chk("late_timeout", 0, 1);
      exp_q.delete();
      exp_q.push_back(1);
`ifdef GRP_SCAN_RESNAP_EN
      exp_q.push_back(3);
`endif
      cmp_order("late");
      gnt_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
